// File: rtl/dmem_pkg.sv
// Shared types for the byte-banked data memory pipeline: FSM state encoding,
// lane-count helper and the response-stage record carried down the pipe.
package dmem_pkg;

    // Two-state access sequencer: IDLE accepts, SPLIT finishes the second row.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    // Widest data path the response record can carry; DATA_W must stay below it.
    localparam int RSP_DATA_MAX = 512;

    // One response-pipeline stage. Only data[DATA_W-1:0] is meaningful.
    typedef struct packed {
        logic                    valid;
        logic                    error;
        logic [RSP_DATA_MAX-1:0] data;
    } rsp_stage_t;

    // Number of byte lanes in a data word.
    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of storage: single-port RAM, synchronous read, write enable.
// Read data holds its last value when the port is idle or writing.
module dmem_byte_bank
    import dmem_pkg::*;
#(
    parameter int ROWS  = 1024,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [ROW_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [ROWS];
    logic [7:0] rdata_q;

    // Port access: write enabled byte or register the addressed byte.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_pipe.sv
// Byte-addressed data memory with unaligned access support. Accesses that
// straddle two rows take two beats (IDLE then SPLIT); everything else takes
// one. Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready drops only during SPLIT and reset, and
// every transfer yields exactly one rsp_valid pulse, in order.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [lanes_of(DATA_W)-1:0]  req_wmask,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_error
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int ROWS  = DEPTH_BYTES / LANES;
    localparam int ROW_W = $clog2(ROWS);
    localparam int LOG_L = $clog2(LANES);
    localparam int OFF_W = (LOG_L > 0) ? LOG_L : 1;

    // ---------------- request decode ----------------
    logic [OFF_W-1:0] req_off;
    logic [ROW_W-1:0] req_row;
    logic [ADDR_W:0]  req_end;
    logic             req_err;
    logic             req_split;
    logic             accept;

    // Lane offset, row, range check and split detection for the incoming request.
    always_comb begin
        int hi;
        req_off = req_addr[OFF_W-1:0] & OFF_W'(LANES - 1);
        req_row = req_addr[LOG_L +: ROW_W];
        // Full-width sum so high address bits push out of range instead of wrapping.
        req_end = {1'b0, req_addr} + (ADDR_W + 1)'(LANES - 1);
        req_err = (req_end >= (ADDR_W + 1)'(DEPTH_BYTES));
        hi = -1;
        for (int i = 0; i < LANES; i++) begin
            if (req_wmask[i]) hi = i;
        end
        if (req_err) begin
            req_split = 1'b0;
        end else if (req_write) begin
            req_split = (hi >= 0) && (int'(req_off) + hi >= LANES);
        end else begin
            req_split = (req_off != '0);
        end
    end

    // ---------------- FSM and latched request ----------------
    state_e                state_q, state_d;
    logic                  lat_write_q, lat_write_d;
    logic [OFF_W-1:0]      lat_off_q, lat_off_d;
    logic [ROW_W-1:0]      lat_row_q, lat_row_d;
    logic [DATA_W-1:0]     lat_wdata_q, lat_wdata_d;
    logic [LANES-1:0]      lat_wmask_q, lat_wmask_d;

    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // Next state and capture of the request whose second beat runs in SPLIT.
    always_comb begin
        state_d     = state_q;
        lat_write_d = lat_write_q;
        lat_off_d   = lat_off_q;
        lat_row_d   = lat_row_q;
        lat_wdata_d = lat_wdata_q;
        lat_wmask_d = lat_wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && req_split) begin
                    state_d     = ST_SPLIT;
                    lat_write_d = req_write;
                    lat_off_d   = req_off;
                    lat_row_d   = req_row + ROW_W'(1);
                    lat_wdata_d = req_wdata;
                    lat_wmask_d = req_wmask;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_write_q <= 1'b0;
            lat_off_q   <= '0;
            lat_row_q   <= '0;
            lat_wdata_q <= '0;
            lat_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_write_q <= lat_write_d;
            lat_off_q   <= lat_off_d;
            lat_row_q   <= lat_row_d;
            lat_wdata_q <= lat_wdata_d;
            lat_wmask_q <= lat_wmask_d;
        end
    end

    // ---------------- bank control ----------------
    logic [LANES-1:0]  bank_en;
    logic [LANES-1:0]  bank_we;
    logic [ROW_W-1:0]  bank_row;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata;

    // Steer each lane: lane l carries request byte (l - off) mod LANES. Lanes at or
    // above the offset belong to beat 0 (row r), lanes below it to beat 1 (row r+1).
    always_comb begin
        bank_en    = '0;
        bank_we    = '0;
        bank_row   = req_row;
        bank_wdata = '0;
        for (int l = 0; l < LANES; l++) begin
            int j;
            if (state_q == ST_IDLE) begin
                j = (l + LANES - int'(req_off)) % LANES;
                bank_wdata[l*8 +: 8] = req_wdata[j*8 +: 8];
                if (accept && !req_err) begin
                    if (req_write) begin
                        bank_we[l] = (l >= int'(req_off)) && req_wmask[j];
                        bank_en[l] = bank_we[l];
                    end else begin
                        bank_en[l] = 1'b1;
                    end
                end
            end else begin
                j = (l + LANES - int'(lat_off_q)) % LANES;
                bank_row             = lat_row_q;
                bank_wdata[l*8 +: 8] = lat_wdata_q[j*8 +: 8];
                if (lat_write_q) begin
                    bank_we[l] = (l < int'(lat_off_q)) && lat_wmask_q[j];
                    bank_en[l] = bank_we[l];
                end else begin
                    bank_en[l] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        dmem_byte_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (bank_we[g]),
            .addr  (bank_row),
            .wdata (bank_wdata[g*8 +: 8]),
            .rdata (bank_rdata[g*8 +: 8])
        );
    end

    // ---------------- final-beat metadata ----------------
    logic              m_valid_q, m_valid_d;
    logic              m_error_q, m_error_d;
    logic              m_write_q, m_write_d;
    logic              m_split_q, m_split_d;
    logic [OFF_W-1:0]  m_off_q, m_off_d;
    logic [DATA_W-1:0] beat0_q, beat0_d;

    // Record the access whose last beat is happening now; keep beat 0 read data.
    always_comb begin
        m_valid_d = 1'b0;
        m_error_d = 1'b0;
        m_write_d = 1'b0;
        m_split_d = 1'b0;
        m_off_d   = '0;
        beat0_d   = beat0_q;
        if (state_q == ST_SPLIT) begin
            m_valid_d = 1'b1;
            m_write_d = lat_write_q;
            m_split_d = 1'b1;
            m_off_d   = lat_off_q;
            beat0_d   = bank_rdata;
        end else if (accept && !req_split) begin
            m_valid_d = 1'b1;
            m_error_d = req_err;
            m_write_d = req_write;
            m_off_d   = req_off;
        end
    end

    // Metadata registers; cleared on reset so in-flight work is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_error_q <= 1'b0;
            m_write_q <= 1'b0;
            m_split_q <= 1'b0;
            m_off_q   <= '0;
            beat0_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_error_q <= m_error_d;
            m_write_q <= m_write_d;
            m_split_q <= m_split_d;
            m_off_q   <= m_off_d;
            beat0_q   <= beat0_d;
        end
    end

    // ---------------- response pipeline ----------------
    rsp_stage_t stage0;
    rsp_stage_t rsp_out;

    // Reassemble bytes addr..addr+LANES-1: byte j sits in lane (off+j) mod LANES,
    // taken from the saved row-r word when it did not wrap into row r+1.
    always_comb begin
        logic [DATA_W-1:0] word;
        word = '0;
        for (int j = 0; j < LANES; j++) begin
            int lane;
            lane = (int'(m_off_q) + j) % LANES;
            if (m_split_q && (int'(m_off_q) + j < LANES)) begin
                word[j*8 +: 8] = beat0_q[lane*8 +: 8];
            end else begin
                word[j*8 +: 8] = bank_rdata[lane*8 +: 8];
            end
        end
        stage0       = '0;
        stage0.valid = m_valid_q;
        stage0.error = m_error_q;
        if (m_valid_q && !m_error_q && !m_write_q) begin
            stage0.data[DATA_W-1:0] = word;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign rsp_out = stage0;
    end else begin : g_latn
        rsp_stage_t pipe_q [READ_LATENCY-1];
        rsp_stage_t pipe_d [READ_LATENCY-1];

        // Shift responses one stage per cycle.
        always_comb begin
            pipe_d[0] = stage0;
            for (int k = 1; k < READ_LATENCY - 1; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end

        // Pipeline registers, cleared on reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < READ_LATENCY - 1; k++) pipe_q[k] <= '0;
            end else begin
                for (int k = 0; k < READ_LATENCY - 1; k++) pipe_q[k] <= pipe_d[k];
            end
        end

        assign rsp_out = pipe_q[READ_LATENCY-2];
    end

    logic unused_hi;
    assign unused_hi = ^rsp_out.data[RSP_DATA_MAX-1:DATA_W];

    assign rsp_valid = rsp_out.valid;
    assign rsp_error = rsp_out.error;
    assign rsp_rdata = rsp_out.data[DATA_W-1:0];

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe at default parameters (32-bit, 4 KiB, latency 1).
module tb_dmem_pipe;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;

    dmem_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, then watch six cycles for response
    // latency, pulse count, stall cycles, data and error.
    task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m,
                             input int exp_lat, input int exp_stall,
                             input logic [31:0] exp_data, input logic exp_err);
        int          lat;
        int          pulses;
        int          stalls;
        logic [31:0] got_d;
        logic        got_e;
        check({tag, " ready_before"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; pulses = 0; stalls = 0; got_d = '0; got_e = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat   = i;
                    got_d = rsp_rdata;
                    got_e = rsp_error;
                end
            end
            if (!req_ready) stalls++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " pulses"}, 64'(pulses), 64'd1);
        check({tag, " stalls"}, 64'(stalls), 64'(exp_stall));
        check({tag, " rdata"}, 64'(got_d), 64'(exp_data));
        check({tag, " error"}, 64'(got_e), 64'(exp_err));
    endtask

    initial begin
        int pulses;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset rsp_error", 64'(rsp_error), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned full write then read
        do_access("wr10", 1'b1, 32'h10, 32'hDDCCBBAA, 4'hF, 1, 0, 32'h0, 1'b0);
        do_access("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 1, 0, 32'hDDCCBBAA, 1'b0);

        // Partial mask write
        do_access("wr20", 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1, 0, 32'h0, 1'b0);
        do_access("wr20m", 1'b1, 32'h20, 32'h11223344, 4'h5, 1, 0, 32'h0, 1'b0);
        do_access("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 1, 0, 32'hFF22FF44, 1'b0);

        // Unaligned split read
        do_access("wr14", 1'b1, 32'h14, 32'h44332211, 4'hF, 1, 0, 32'h0, 1'b0);
        do_access("rd12", 1'b0, 32'h12, 32'h0, 4'h0, 2, 1, 32'h2211DDCC, 1'b0);

        // Split write: offset 3, mask 0x3 puts 0x88 at 0x13 and 0x77 at 0x14
        do_access("wr13s", 1'b1, 32'h13, 32'h55667788, 4'h3, 2, 1, 32'h0, 1'b0);
        do_access("rd10b", 1'b0, 32'h10, 32'h0, 4'h0, 1, 0, 32'h88CCBBAA, 1'b0);
        do_access("rd14b", 1'b0, 32'h14, 32'h0, 4'h0, 1, 0, 32'h44332277, 1'b0);

        // Unaligned write that stays in one row is single-beat
        do_access("wr21", 1'b1, 32'h21, 32'h000000AB, 4'h1, 1, 0, 32'h0, 1'b0);
        do_access("rd20b", 1'b0, 32'h20, 32'h0, 4'h0, 1, 0, 32'hFF22AB44, 1'b0);

        // Zero-mask write: response but no storage change
        do_access("wr20z", 1'b1, 32'h20, 32'h12345678, 4'h0, 1, 0, 32'h0, 1'b0);
        do_access("rd20c", 1'b0, 32'h20, 32'h0, 4'h0, 1, 0, 32'hFF22AB44, 1'b0);

        // Out-of-range accesses
        do_access("wrFFC", 1'b1, 32'hFFC, 32'h01020304, 4'hF, 1, 0, 32'h0, 1'b0);
        do_access("rdFFE", 1'b0, 32'hFFE, 32'h0, 4'h0, 1, 0, 32'h0, 1'b1);
        do_access("wrFFD", 1'b1, 32'hFFD, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0, 1'b1);
        do_access("rdFFC", 1'b0, 32'hFFC, 32'h0, 4'h0, 1, 0, 32'h01020304, 1'b0);
        do_access("rd1010", 1'b0, 32'h1010, 32'h0, 4'h0, 1, 0, 32'h0, 1'b1);

        // Back-to-back write then read of the same word
        check("b2b ready0", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
        req_wdata = 32'hCAFEBABE; req_wmask = 4'hF;
        @(negedge clk);
        check("b2b ready1", 64'(req_ready), 64'd1);
        check("b2b wr rsp_valid", 64'(rsp_valid), 64'd1);
        check("b2b wr rsp_rdata", 64'(rsp_rdata), 64'd0);
        req_write = 1'b0; req_wdata = '0; req_wmask = '0;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b rd rsp_valid", 64'(rsp_valid), 64'd1);
        check("b2b rd rsp_rdata", 64'(rsp_rdata), 64'hCAFEBABE);
        check("b2b rd rsp_error", 64'(rsp_error), 64'd0);
        @(negedge clk);
        check("b2b single pulse", 64'(rsp_valid), 64'd0);

        // Reset during SPLIT of a split write: beat 0 stays, beat 1 never happens
        do_access("wr4C", 1'b1, 32'h4C, 32'h0, 4'hF, 1, 0, 32'h0, 1'b0);
        do_access("wr50", 1'b1, 32'h50, 32'h0, 4'hF, 1, 0, 32'h0, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4E;
        req_wdata = 32'hA1B2C3D4; req_wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst split ready", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst mid rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst mid req_ready", 64'(req_ready), 64'd0);
        check("rst mid rsp_rdata", 64'(rsp_rdata), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst release ready", 64'(req_ready), 64'd1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rst no response", 64'(pulses), 64'd0);
        do_access("rd4C", 1'b0, 32'h4C, 32'h0, 4'h0, 1, 0, 32'hC3D40000, 1'b0);
        do_access("rd50", 1'b0, 32'h50, 32'h0, 4'h0, 1, 0, 32'h00000000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
